// File: rtl/kernel_dispatch.sv
// Kernel dispatcher: splits thread_count into fixed-size blocks and hands them to free cores.
// Optional cycle counter on kernel_cycles is built when DISPATCH_PERF_EN is defined.
module kernel_dispatch #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int BLOCK_ID_W        = 16,
    parameter int TPB_W             = 7
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [15:0]                      thread_count,
    input  logic [NUM_CORES-1:0]             core_done,
    output logic [NUM_CORES-1:0]             core_start,
    output logic [NUM_CORES*BLOCK_ID_W-1:0]  core_block_id,
    output logic [NUM_CORES*TPB_W-1:0]       core_thread_count,
    output logic                             done,
    output logic [31:0]                      kernel_cycles
);

    localparam int                    SHIFT      = $clog2(THREADS_PER_BLOCK);
    localparam logic [15:0]           REM_MASK   = 16'(THREADS_PER_BLOCK - 1);
    localparam logic [TPB_W-1:0]      FULL_COUNT = TPB_W'(THREADS_PER_BLOCK);
    localparam logic [BLOCK_ID_W-1:0] ONE        = BLOCK_ID_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DISPATCH, S_COMPLETE} state_t;

    state_t                                 state_q, state_d;
    logic [15:0]                            tc_q, tc_d;
    logic [BLOCK_ID_W-1:0]                  total_blocks_q, total_blocks_d;
    logic [TPB_W-1:0]                       last_count_q, last_count_d;
    logic [BLOCK_ID_W-1:0]                  next_block_q, next_block_d;
    logic [BLOCK_ID_W-1:0]                  blocks_done_q, blocks_done_d;
    logic [NUM_CORES-1:0]                   busy_q, busy_d;
    logic [NUM_CORES-1:0]                   core_start_q, core_start_d;
    logic [NUM_CORES-1:0][BLOCK_ID_W-1:0]   core_block_id_q, core_block_id_d;
    logic [NUM_CORES-1:0][TPB_W-1:0]        core_thread_count_q, core_thread_count_d;
    logic                                   done_q, done_d;

    logic [15:0]          rem;
    logic [16:0]          blocks_calc;
    logic [NUM_CORES-1:0] valid_done;
    logic                 issued;

    // ceil(tc / TPB) as a shift plus a carry-in when any remainder bit is set.
    assign rem         = tc_q & REM_MASK;
    assign blocks_calc = {1'b0, tc_q >> SHIFT} + {16'd0, |rem};
    // Completions from cores that hold no block are dropped.
    assign valid_done  = core_done & busy_q;

    always_comb begin
        // NOTE: every _d defaults to its _q so no path through the case leaves a latch.
        state_d             = state_q;
        tc_d                = tc_q;
        total_blocks_d      = total_blocks_q;
        last_count_d        = last_count_q;
        next_block_d        = next_block_q;
        blocks_done_d       = blocks_done_q;
        busy_d              = busy_q;
        core_start_d        = '0;
        core_block_id_d     = core_block_id_q;
        core_thread_count_d = core_thread_count_q;
        done_d              = done_q;
        issued              = 1'b0;

        case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    tc_d    = thread_count;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                total_blocks_d = BLOCK_ID_W'(blocks_calc);
                last_count_d   = (rem == 16'd0) ? FULL_COUNT : TPB_W'(rem);
                next_block_d   = '0;
                blocks_done_d  = '0;
                busy_d         = '0;
                if (blocks_calc == 17'd0) begin
                    state_d = S_COMPLETE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                // Freed slots are taken out of busy_d only; issue looks at busy_q,
                // so a slot freed this edge is reused no earlier than the next.
                busy_d = busy_q & ~valid_done;
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (!issued && !busy_q[i] && (next_block_q < total_blocks_q)) begin
                        issued                 = 1'b1;
                        core_start_d[i]        = 1'b1;
                        busy_d[i]              = 1'b1;
                        core_block_id_d[i]     = next_block_q;
                        core_thread_count_d[i] = (next_block_q == total_blocks_q - ONE)
                                                 ? last_count_q : FULL_COUNT;
                        next_block_d           = next_block_q + ONE;
                    end
                end
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (valid_done[i]) blocks_done_d = blocks_done_d + ONE;
                end
                if (blocks_done_d == total_blocks_q) begin
                    state_d = S_COMPLETE;
                    done_d  = 1'b1;
                end
            end
            S_COMPLETE: begin
                if (!start) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments from the _d values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= S_IDLE;
            tc_q                <= '0;
            total_blocks_q      <= '0;
            last_count_q        <= '0;
            next_block_q        <= '0;
            blocks_done_q       <= '0;
            busy_q              <= '0;
            core_start_q        <= '0;
            core_block_id_q     <= '0;
            core_thread_count_q <= '0;
            done_q              <= 1'b0;
        end else begin
            state_q             <= state_d;
            tc_q                <= tc_d;
            total_blocks_q      <= total_blocks_d;
            last_count_q        <= last_count_d;
            next_block_q        <= next_block_d;
            blocks_done_q       <= blocks_done_d;
            busy_q              <= busy_d;
            core_start_q        <= core_start_d;
            core_block_id_q     <= core_block_id_d;
            core_thread_count_q <= core_thread_count_d;
            done_q              <= done_d;
        end
    end

    assign core_start        = core_start_q;
    assign core_block_id     = core_block_id_q;
    assign core_thread_count = core_thread_count_q;
    assign done              = done_q;

`ifdef DISPATCH_PERF_EN
    logic [31:0] kernel_cycles_q, kernel_cycles_d;

    // Cleared on launch, counts LOAD and DISPATCH cycles, saturates, frozen otherwise.
    always_comb begin
        kernel_cycles_d = kernel_cycles_q;
        if (state_q == S_IDLE && start) begin
            kernel_cycles_d = '0;
        end else if ((state_q == S_LOAD || state_q == S_DISPATCH) && kernel_cycles_q != '1) begin
            kernel_cycles_d = kernel_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) kernel_cycles_q <= '0;
        else       kernel_cycles_q <= kernel_cycles_d;
    end

    assign kernel_cycles = kernel_cycles_q;
`else
    assign kernel_cycles = 32'd0;
`endif

endmodule

// File: doc/kernel_dispatch.md
Name: kernel_dispatch

Overview:
- Consumes the device-control thread_count value and launches a kernel across the compute cores.
- Splits thread_count into fixed-size blocks and hands one block at a time to free cores over a start/done handshake.
- Raises done to the host-side controller once every block has completed.
- Sits between the device control register, the host start strobe and the core array.

Parameters:
- NUM_CORES, 2, number of cores served; 1..8.
- THREADS_PER_BLOCK, 4, threads per block; power of two, 1..64.
- BLOCK_ID_W, 16, width of the block index.
- TPB_W, 7, width of the per-block thread count; must hold THREADS_PER_BLOCK.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- start  input  1  host launch request, level; held high until done is seen.
- thread_count  input  16  total threads for the kernel, from the device control register.
- core_done  input  NUM_CORES  per-core one-cycle pulse: assigned block finished.
- core_start  output  NUM_CORES  per-core one-cycle pulse: block assigned.
- core_block_id  output  NUM_CORES*BLOCK_ID_W  per-core block index; stable while the core is busy.
- core_thread_count  output  NUM_CORES*TPB_W  per-core active thread count for the assigned block.
- done  output  1  kernel complete.
- kernel_cycles  output  32  performance counter (see Optional Feature).

Behaviour:
- Reset:
  - state=IDLE; all core slots free; counters zero.
  - Outputs core_start=0, core_block_id=0, core_thread_count=0, done=0, kernel_cycles=0.
  - Reset is honoured in any state and aborts an in-flight kernel; no further core_start is issued.
- FSM states: IDLE, LOAD, DISPATCH, COMPLETE.
- IDLE:
  - start sampled high at edge E0 -> LOAD.
  - thread_count latched at E0; later changes to the input are ignored until the next launch.
- LOAD:
  - total_blocks = ceil(thread_count / THREADS_PER_BLOCK), computed with a shift plus a remainder check.
  - last_count = thread_count mod THREADS_PER_BLOCK, or THREADS_PER_BLOCK when the remainder is 0.
  - At E1 -> DISPATCH. If total_blocks==0 -> COMPLETE instead.
- DISPATCH:
  - Each cycle, if next_block < total_blocks and any core is free, issue to the lowest-index free core.
  - Issue means: core_start pulses high for one cycle; core_block_id = next_block; core_thread_count = last_count for the final block, THREADS_PER_BLOCK otherwise.
  - The slot is marked busy and next_block increments.
  - At most one issue per cycle. The first issue is registered at E2, i.e. 2 cycles after start is sampled.
  - core_done on a busy core frees the slot and increments blocks_done. Multiple core_done bits in one cycle are all counted.
  - core_done on a free core is ignored.
  - A slot freed by core_done at edge N is eligible for issue at edge N+1; there is no same-edge reuse.
  - When blocks_done == total_blocks -> COMPLETE.
- COMPLETE:
  - done=1, registered; held while start=1.
  - start low -> IDLE at the next edge, done cleared at that edge.
- Widths: blocks_done and next_block are BLOCK_ID_W bits. For thread_count=65535 and THREADS_PER_BLOCK=1, the count 65535 fits.

Optional Feature:
- Macro: DISPATCH_PERF_EN.
- Defined:
  - kernel_cycles clears at the IDLE->LOAD edge and increments each cycle in LOAD and DISPATCH.
  - It freezes in COMPLETE and holds its value until the next launch.
  - It saturates at 32'hFFFFFFFF.
- Undefined: kernel_cycles is tied to 0 and no counter logic is built.

Test Plan:
- thread_count=8, start=1 -> core_start=2'b01 at E2 (block 0, count 4), 2'b10 at E3 (block 1, count 4). core_done pulses on both -> done=1 the cycle after the second pulse.
- thread_count=10 -> blocks 0,1 issued immediately. Block 2 (core_thread_count=2) is issued to core0 one cycle after its core_done pulse. done after 3 completions.
- thread_count=0, start=1 -> no core_start; done=1 after E1 (2 edges after start). start=0 -> done=0 next edge, state IDLE.
- Same cycle: core_done[0]=1 while block 1 is issuing to core1, thread_count=12 -> block 2 goes to core0 exactly one edge later. Simultaneous core_done=2'b11 counts as 2.
- reset asserted mid-DISPATCH with 2 blocks outstanding -> all outputs 0 next edge. Later core_done pulses are ignored. A fresh launch with thread_count=4 completes normally.
- DISPATCH_PERF_EN defined, thread_count=4, core_done 5 cycles after core_start -> kernel_cycles=7, stable while done=1. Macro undefined -> kernel_cycles=0 throughout.
